// File: rtl/j_chunk_streamer.sv
// j_chunk_streamer: reads the J matrix one column chunk per memory word and streams the chunks in order to the MatMul energy engine.
// Latency: the first chunk is valid 2 cycles after start is accepted; with chunk_ready held high, one chunk per cycle after that.
// Backpressure: reads are throttled so that in-flight plus buffered chunks never exceed FIFO_DEPTH; JCS_STALL_CNT_EN adds the stall_cycles counter.

// jcs_fifo: first-word-fall-through chunk buffer with a synchronous flush.
// Latency: a pushed entry is visible at head_dat on the cycle after the push.
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle.
module jcs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push_vld,
  input  logic [WIDTH-1:0]           push_dat,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_dat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push_vld && ((count != CW'(DEPTH)) || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

module j_chunk_streamer #(
  parameter int MEM_BANDWIDTH   = 4096,
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int ADDR_WIDTH      = 16,
  parameter int FIFO_DEPTH      = 2,
  localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
  localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
  localparam int IDX_W           = $clog2(NUM_J_CHUNKS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_ren,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  input  logic [MEM_BANDWIDTH-1:0] mem_rdata,
  output logic                     chunk_valid,
  input  logic                     chunk_ready,
  output logic [MEM_BANDWIDTH-1:0] chunk_data,
  output logic [IDX_W-1:0]         chunk_idx,
  output logic                     chunk_last,
  output logic [31:0]              stall_cycles
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t                          state;
  logic [ADDR_WIDTH-1:0]           base_q;
  logic [IDX_W-1:0]                issue_cnt;
  logic [IDX_W-1:0]                inflight_idx;
  logic                            inflight;
  logic [CW-1:0]                   fifo_count;
  logic                            fifo_empty;
  logic                            pop;
  logic                            push;
  logic [MEM_BANDWIDTH+IDX_W-1:0]  head;
  logic [OW-1:0]                   occ;
  logic [OW-1:0]                   occ_lim;

  assign busy        = (state != IDLE);
  assign chunk_valid = !fifo_empty;
  assign {chunk_idx, chunk_data} = head;
  assign chunk_last  = (chunk_idx == IDX_W'(NUM_J_CHUNKS - 1));
  assign pop         = chunk_valid && chunk_ready;
  assign push        = inflight && !abort;

  // Same-cycle pop frees a slot, which is what lets a depth-2 buffer sustain one chunk per cycle.
  assign occ     = {1'b0, fifo_count} + OW'(inflight);
  assign occ_lim = OW'(FIFO_DEPTH) + OW'(pop);
  assign mem_ren = (state == STREAM) && !abort && (occ < occ_lim);
  assign mem_addr = base_q + ADDR_WIDTH'(issue_cnt);

  jcs_fifo #(
    .WIDTH (MEM_BANDWIDTH + IDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (abort),
    .push_vld (push),
    .push_dat ({inflight_idx, mem_rdata}),
    .pop      (pop),
    .head_dat (head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base_q       <= '0;
      issue_cnt    <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      done         <= 1'b0;
    end else begin
      done     <= 1'b0;
      inflight <= mem_ren;
      if (mem_ren) begin
        inflight_idx <= issue_cnt;
        issue_cnt    <= issue_cnt + IDX_W'(1);
      end
      case (state)
        IDLE: begin
          if (start && !abort) begin
            base_q    <= base_addr;
            issue_cnt <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (abort) state <= IDLE;
          else if (mem_ren && (issue_cnt == IDX_W'(NUM_J_CHUNKS - 1))) state <= DRAIN;
        end
        DRAIN: begin
          if (abort) begin
            state <= IDLE;
          end else if (pop && chunk_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef JCS_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start && !abort) begin
      stall_cycles <= '0;
    end else if (chunk_valid && !chunk_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif
endmodule

// File: tb/tb_j_chunk_streamer.sv
// Bench for j_chunk_streamer: control table from reset, then randomized passes against a chunk-sequence model.
module tb_j_chunk_streamer;
  localparam int MB  = 4096;
  localparam int VS  = 256;
  localparam int JW  = 4;
  localparam int AW  = 16;
  localparam int FD  = 2;
  localparam int JC  = MB / (VS * JW);
  localparam int NCH = VS / JC;
  localparam int IW  = $clog2(NCH);

  logic          clk = 1'b0;
  logic          rst_n, start, abort, chunk_ready;
  logic [AW-1:0] base_addr, mem_addr;
  logic          busy, done, mem_ren, chunk_valid, chunk_last;
  logic [MB-1:0] mem_rdata, chunk_data;
  logic [IW-1:0] chunk_idx;
  logic [31:0]   stall_cycles;

  always #5 clk = ~clk;

  j_chunk_streamer #(
    .MEM_BANDWIDTH (MB), .VECTOR_SIZE (VS), .J_ELEMENT_WIDTH (JW),
    .ADDR_WIDTH (AW), .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .base_addr (base_addr), .busy (busy), .done (done),
    .mem_ren (mem_ren), .mem_addr (mem_addr), .mem_rdata (mem_rdata),
    .chunk_valid (chunk_valid), .chunk_ready (chunk_ready),
    .chunk_data (chunk_data), .chunk_idx (chunk_idx),
    .chunk_last (chunk_last), .stall_cycles (stall_cycles)
  );

  logic [JW-1:0] jm [VS][VS];
  logic [MB-1:0] exp_w [NCH];
  int            n_chk = 0, n_pass = 0;
  bit            mon_on, pend_ren, hold_pending, done_exp, pass_over;
  logic [AW-1:0] pend_addr, cur_base;
  int            n_iss, n_acc, max_occ, stall_exp;
  logic [IW-1:0] held_idx;
  logic [MB-1:0] held_data;

  typedef struct {
    bit st; bit ab; bit rdy;
    bit busy; bit ren; bit vld; int off; int idx;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
  endtask

  // Fresh random J; chunk k packs columns k*JC..k*JC+JC-1 of every row.
  task automatic new_pass(input logic [AW-1:0] b);
    for (int r = 0; r < VS; r++)
      for (int c = 0; c < VS; c++) jm[r][c] = 4'($urandom);
    for (int k = 0; k < NCH; k++)
      for (int r = 0; r < VS; r++)
        for (int c = 0; c < JC; c++) exp_w[k][(r*JC+c)*JW +: JW] = jm[r][k*JC+c];
    cur_base = b; n_iss = 0; n_acc = 0; max_occ = 0; stall_exp = 0;
    hold_pending = 0; done_exp = 0; pass_over = 0; mon_on = 1;
  endtask

  task automatic reset_checks();
    chk(busy == 1'b0, "rst_busy", busy, 0);
    chk(done == 1'b0, "rst_done", done, 0);
    chk(mem_ren == 1'b0, "rst_mem_ren", mem_ren, 0);
    chk(mem_addr == '0, "rst_mem_addr", mem_addr, 0);
    chk(chunk_valid == 1'b0, "rst_chunk_valid", chunk_valid, 0);
    chk(chunk_idx == '0, "rst_chunk_idx", chunk_idx, 0);
    chk(chunk_last == 1'b0, "rst_chunk_last", chunk_last, 0);
    chk(chunk_data == '0, "rst_chunk_data", chunk_data[63:0], 0);
    chk(stall_cycles == '0, "rst_stall_cycles", stall_cycles, 0);
  endtask

  task automatic monitor();
    logic [AW-1:0] ea;
    pend_ren  = mem_ren;
    pend_addr = mem_addr;
    if (!mon_on) return;
    if (done_exp || done) begin
      chk(done == done_exp, "done_pulse", done, done_exp);
      if (done_exp) begin
        chk(busy == 1'b0, "busy_after_done", busy, 0);
        pass_over = 1;
      end
    end
    done_exp = 0;
    if (hold_pending)
      chk(chunk_valid && chunk_idx == held_idx && chunk_data == held_data, "hold_stable", chunk_idx, held_idx);
    if (mem_ren) begin
      ea = cur_base + AW'(n_iss);
      chk(mem_addr == ea, "rd_addr", mem_addr, ea);
      n_iss++;
    end
    if (chunk_valid && chunk_ready) begin
      if (n_acc >= NCH) begin
        chk(1'b0, "extra_chunk", chunk_idx, n_acc);
      end else begin
        chk(chunk_idx == IW'(n_acc), "chunk_idx", chunk_idx, n_acc);
        chk(chunk_data == exp_w[n_acc], "chunk_data", chunk_data[63:0], exp_w[n_acc][63:0]);
        chk(chunk_last == (n_acc == NCH - 1), "chunk_last", chunk_last, n_acc == NCH - 1);
      end
      n_acc++;
      if (n_acc == NCH) done_exp = 1;
    end
    if (chunk_valid && !chunk_ready) stall_exp++;
    hold_pending = chunk_valid && !chunk_ready;
    held_idx     = chunk_idx;
    held_data    = chunk_data;
    if (n_iss - n_acc > max_occ) max_occ = n_iss - n_acc;
  endtask

  // Memory model: data for the address requested last cycle, junk otherwise.
  task automatic post();
    logic [AW-1:0] off;
    @(posedge clk);
    #1;
    off = pend_addr - cur_base;
    if (pend_ren && off < AW'(NCH)) mem_rdata = exp_w[off[IW-1:0]];
    else mem_rdata = {128{32'hDEADBEEF}};
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    post();
  endtask

  // ev: 0 none, 1 abort at chunk 17, 2 start pulse at chunk 30, 3 reset at chunk 40
  task automatic run_pass(input logic [AW-1:0] b, input int duty, input int ev);
    bit ev_done = 0;
    bit bad = 0;
    new_pass(b);
    base_addr = b; start = 1; abort = 0; chunk_ready = 0;
    cycle();
    for (int cyc = 0; cyc < 2000 && !pass_over; cyc++) begin
      chunk_ready = ($urandom_range(99) < duty);
      start = 0; abort = 0; base_addr = b;
      if (!ev_done && ev == 2 && n_acc == 30) begin
        start = 1; base_addr = b ^ 16'h5555; ev_done = 1;
      end
      if (!ev_done && ev == 1 && n_acc == 17) begin
        abort = 1; chunk_ready = 0; ev_done = 1;
      end
      if (!ev_done && ev == 3 && n_acc == 40) begin
        ev_done = 1;
        #2 rst_n = 0;
        #1 reset_checks();
        mon_on = 0; pend_ren = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        return;
      end
      cycle();
      if (abort) begin
        abort = 0; mon_on = 0;
        @(negedge clk);
        chk(chunk_valid == 1'b0, "abort_valid_drop", chunk_valid, 0);
        chk(busy == 1'b0, "abort_busy", busy, 0);
        chk(done == 1'b0, "abort_no_done", done, 0);
        monitor();
        post();
        repeat (4) begin
          @(negedge clk);
          if (done || busy || mem_ren || chunk_valid) bad = 1;
          monitor();
          post();
        end
        chk(!bad, "abort_quiet", bad, 0);
        return;
      end
    end
    start = 0;
    if (!pass_over) begin
      chk(1'b0, "pass_timeout", n_acc, NCH);
      return;
    end
    chk(n_acc == NCH, "chunk_count", n_acc, NCH);
    chk(n_iss == NCH, "read_count", n_iss, NCH);
    chk(max_occ <= FD, "max_outstanding", max_occ, FD);
    repeat (2) cycle();
`ifdef JCS_STALL_CNT_EN
    chk(stall_cycles == 32'(stall_exp), "stall_cycles", stall_cycles, stall_exp);
`else
    chk(stall_cycles == '0, "stall_cycles_tied", stall_cycles, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 0; start = 0; abort = 0; chunk_ready = 0; base_addr = '0;
    mem_rdata = '0; mon_on = 0; pend_ren = 0; pend_addr = '0; cur_base = '0;
    #2 reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    //            st ab rdy busy ren vld off idx
    tbl[0]  = '{0, 0, 0, 0, 0, 0, -1, -1};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, -1, -1};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, -1, -1};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, -1, -1};
    tbl[4]  = '{0, 0, 0, 1, 1, 0,  0, -1};
    tbl[5]  = '{0, 0, 0, 1, 1, 0,  1, -1};
    tbl[6]  = '{0, 0, 0, 1, 0, 1, -1,  0};
    tbl[7]  = '{0, 0, 0, 1, 0, 1, -1,  0};
    tbl[8]  = '{0, 0, 1, 1, 1, 1,  2,  0};
    tbl[9]  = '{0, 0, 0, 1, 0, 1, -1,  1};
    tbl[10] = '{0, 1, 0, 1, 0, 1, -1,  1};
    tbl[11] = '{0, 0, 0, 0, 0, 0, -1, -1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, -1, -1};
    new_pass(16'h0200);
    mon_on = 0;
    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; abort = tbl[i].ab; chunk_ready = tbl[i].rdy; base_addr = 16'h0200;
      @(negedge clk);
      chk(busy == tbl[i].busy, $sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
      chk(mem_ren == tbl[i].ren, $sformatf("tbl%0d_ren", i), mem_ren, tbl[i].ren);
      chk(chunk_valid == tbl[i].vld, $sformatf("tbl%0d_valid", i), chunk_valid, tbl[i].vld);
      if (tbl[i].off >= 0)
        chk(mem_addr == 16'h0200 + AW'(tbl[i].off), $sformatf("tbl%0d_addr", i), mem_addr, 16'h0200 + tbl[i].off);
      if (tbl[i].idx >= 0) begin
        chk(chunk_idx == IW'(tbl[i].idx), $sformatf("tbl%0d_idx", i), chunk_idx, tbl[i].idx);
        chk(chunk_data == exp_w[tbl[i].idx], $sformatf("tbl%0d_data", i), chunk_data[63:0], exp_w[tbl[i].idx][63:0]);
      end
      monitor();
      post();
    end
    start = 0; abort = 0; chunk_ready = 0;

    void'($urandom(32'hA11A));
    run_pass(16'h0100, 100, 0);
    run_pass(16'h0400, 30, 0);
    run_pass(16'h0100, 100, 1);
    run_pass(16'h0800, 100, 0);
    run_pass(16'h1000, 100, 2);
    run_pass(16'hFFF0, 100, 0);
    run_pass(16'h2000, 100, 3);
    run_pass(16'h3000, 60, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
